// File: rtl/keccak_pkg.sv
// Shared constants and state encoding for the Keccak padder and its helpers.
package keccak_pkg;

  localparam int KECCAK_WORD_W     = 64;
  localparam int KECCAK_RATE_WORDS = 9;

  localparam logic [7:0] PAD_FIRST = 8'h01;
  localparam logic [7:0] PAD_LAST  = 8'h80;

  typedef enum logic [1:0] {
    ABSORB     = 2'd0,
    PAD        = 2'd1,
    FULL_FINAL = 2'd2
  } padder_state_t;

endpackage

// File: rtl/keccak_pad_word.sv
// Combinational pad10*1 word former: masks the tail of the last message word,
// inserts the 0x01 start marker and, in the final rate slot, the 0x80 end marker.
module keccak_pad_word
  import keccak_pkg::*;
#(
  parameter int WORD_W = KECCAK_WORD_W
) (
  input  logic [WORD_W-1:0] in,
  input  logic [2:0]        byte_num,
  input  logic              is_last,
  input  logic              is_final_word,
  output logic [WORD_W-1:0] padded
);

  localparam int BYTES = WORD_W / 8;

  // Byte 0 sits at the MSBs; bytes past the valid count are replaced by 0x01 then zeros.
  always_comb begin
    padded = in;
    if (is_last) begin
      for (int b = 0; b < BYTES; b++) begin
        if (b == int'(byte_num)) begin
          padded[WORD_W-1-8*b -: 8] = PAD_FIRST;
        end else if (b > int'(byte_num)) begin
          padded[WORD_W-1-8*b -: 8] = 8'h00;
        end
      end
    end
    if (is_final_word) begin
      padded[7:0] = padded[7:0] | PAD_LAST;
    end
  end

endmodule

// File: rtl/keccak_padder.sv
// Keccak input padder: packs message words into RATE_WORDS-wide rate blocks,
// applies pad10*1 and hands each block downstream via out_ready / f_ack.
module keccak_padder
  import keccak_pkg::*;
#(
  parameter int WORD_W     = KECCAK_WORD_W,
  parameter int RATE_WORDS = KECCAK_RATE_WORDS,
  parameter int CNT_W      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WORD_W-1:0]            in,
  input  logic                         in_ready,
  input  logic                         is_last,
  input  logic [2:0]                   byte_num,
  output logic                         buffer_full,
  output logic [WORD_W*RATE_WORDS-1:0] out,
  output logic                         out_ready,
  output logic                         out_last,
  input  logic                         f_ack
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RATE_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATE_WORDS - 1);

  padder_state_t     state, state_next;
  logic [CNT_W-1:0]  count;
  logic              full_q;
  logic              shift_en;
  logic              take_block;
  logic              word_last;
  logic              word_final;
  logic [WORD_W-1:0] word_src;
  logic [WORD_W-1:0] padded;

  assign buffer_full = full_q;
  assign out_ready   = full_q;
  assign out_last    = (state == FULL_FINAL);
  assign take_block  = full_q & f_ack;

  keccak_pad_word #(.WORD_W(WORD_W)) u_pad_word (
    .in            (word_src),
    .byte_num      (byte_num),
    .is_last       (word_last),
    .is_final_word (word_final),
    .padded        (padded)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ABSORB;
    end else begin
      state <= state_next;
    end
  end

  // The count==CNT_FULL guard covers the one cycle where the block is full but
  // the registered full flag has not yet risen.
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    word_src   = '0;
    word_last  = 1'b0;
    word_final = 1'b0;
    case (state)
      ABSORB: begin
        if (in_ready && !full_q && count != CNT_FULL) begin
          shift_en   = 1'b1;
          word_src   = in;
          word_last  = is_last;
          word_final = is_last && (count == CNT_LAST);
          if (is_last) begin
            state_next = (count == CNT_LAST) ? FULL_FINAL : PAD;
          end
        end
      end
      PAD: begin
        if (count != CNT_FULL) begin
          shift_en   = 1'b1;
          word_final = (count == CNT_LAST);
          if (count == CNT_LAST) begin
            state_next = FULL_FINAL;
          end
        end else begin
          state_next = FULL_FINAL;
        end
      end
      FULL_FINAL: begin
        if (take_block) begin
          state_next = ABSORB;
        end
      end
      default: begin
        state_next = ABSORB;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      out    <= '0;
      full_q <= 1'b0;
    end else begin
      if (take_block) begin
        count <= '0;
      end else if (shift_en) begin
        count <= count + 1'b1;
        out   <= {out[WORD_W*(RATE_WORDS-1)-1:0], padded};
      end
      full_q <= take_block ? 1'b0 : (count == CNT_FULL);
    end
  end

endmodule

// File: tb/tb_keccak_padder.sv
// Directed self-checking bench for keccak_padder with hand-computed padded blocks.
module tb_keccak_padder;

  localparam int W  = 64;
  localparam int R  = 9;
  localparam int OW = W * R;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic [W-1:0]  in_word  = '0;
  logic          in_ready = 1'b0;
  logic          is_last  = 1'b0;
  logic [2:0]    byte_num = '0;
  logic          f_ack    = 1'b0;
  logic          buffer_full;
  logic [OW-1:0] out_block;
  logic          out_ready;
  logic          out_last;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keccak_padder #(.WORD_W(W), .RATE_WORDS(R), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in          (in_word),
    .in_ready    (in_ready),
    .is_last     (is_last),
    .byte_num    (byte_num),
    .buffer_full (buffer_full),
    .out         (out_block),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .f_ack       (f_ack)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic last, input logic [2:0] bn);
    in_word  = w;
    is_last  = last;
    byte_num = bn;
    in_ready = 1'b1;
    step();
    in_ready = 1'b0;
    is_last  = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!out_ready && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic ack_block();
    f_ack = 1'b1;
    step();
    f_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (out_block !== '0 || out_ready !== 1'b0 || buffer_full !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got out=%h rdy=%b full=%b last=%b exp all zero",
               out_block, out_ready, buffer_full, out_last);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (out_ready !== 1'b0 || out_block !== '0) begin
      errors++;
      $display("[TB] FAIL reset_release got rdy=%b out=%h exp 0", out_ready, out_block);
    end
  endtask

  task automatic test_empty();
    logic [OW-1:0] exp;
    int n;
    exp = {64'h0100000000000000, {7{64'h0}}, 64'h80};
    send_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'd0);
    wait_ready(n);
    checks++;
    if (n !== 9) begin
      errors++;
      $display("[TB] FAIL empty_latency got %0d exp 9", n);
    end
    checks++;
    if (out_block !== exp || out_last !== 1'b1) begin
      errors++;
      $display("[TB] FAIL empty_block got %h last=%b exp %h last=1", out_block, out_last, exp);
    end
    ack_block();
    checks++;
    if (out_ready !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("[TB] FAIL empty_ack got rdy=%b last=%b exp 0 0", out_ready, out_last);
    end
  endtask

  task automatic test_short();
    logic [OW-1:0] exp;
    int n;
    exp = {64'h1122330100000000, {7{64'h0}}, 64'h80};
    send_word(64'h1122334455667788, 1'b1, 3'd3);
    wait_ready(n);
    checks++;
    if (n !== 9 || out_block !== exp || out_last !== 1'b1) begin
      errors++;
      $display("[TB] FAIL short_block got n=%0d %h last=%b exp n=9 %h last=1", n, out_block, out_last, exp);
    end
    checks++;
    if (buffer_full !== 1'b1) begin
      errors++;
      $display("[TB] FAIL short_full_before_ack got %b exp 1", buffer_full);
    end
    ack_block();
    checks++;
    if (buffer_full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL short_full_after_ack got %b exp 0", buffer_full);
    end
  endtask

  task automatic test_final_slot();
    logic [OW-1:0] exp;
    int n;
    for (int i = 0; i < 8; i++) begin
      exp[OW-1-W*i -: W] = 64'h0101010101010101 * 64'(i + 1);
    end
    exp[W-1:0] = 64'hAABBCCDDEEFF0081;
    for (int i = 0; i < 8; i++) begin
      send_word(64'h0101010101010101 * 64'(i + 1), 1'b0, 3'd5);
    end
    send_word(64'hAABBCCDDEEFF0011, 1'b1, 3'd7);
    wait_ready(n);
    checks++;
    if (n !== 1) begin
      errors++;
      $display("[TB] FAIL final_slot_latency got %0d exp 1", n);
    end
    checks++;
    if (out_block !== exp || out_last !== 1'b1) begin
      errors++;
      $display("[TB] FAIL final_slot_block got %h last=%b exp %h last=1", out_block, out_last, exp);
    end
    ack_block();
  endtask

  task automatic test_two_blocks();
    logic [OW-1:0] exp;
    logic [OW-1:0] exp2;
    int n;
    for (int i = 0; i < 9; i++) begin
      exp[OW-1-W*i -: W] = 64'hA5A5_0000_0000_0000 + 64'(i);
      send_word(64'hA5A5_0000_0000_0000 + 64'(i), 1'b0, 3'd2);
    end
    wait_ready(n);
    checks++;
    if (n !== 1 || out_block !== exp || out_last !== 1'b0) begin
      errors++;
      $display("[TB] FAIL two_first_block got n=%0d %h last=%b exp n=1 %h last=0", n, out_block, out_last, exp);
    end
    in_word  = 64'h0102030405060708;
    is_last  = 1'b1;
    byte_num = 3'd2;
    in_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (out_block !== exp || out_ready !== 1'b1 || out_last !== 1'b0) begin
        errors++;
        $display("[TB] FAIL two_hold cycle %0d got rdy=%b last=%b out=%h exp rdy=1 last=0 out=%h",
                 c, out_ready, out_last, out_block, exp);
      end
    end
    ack_block();
    checks++;
    if (out_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL two_ack got rdy=%b exp 0", out_ready);
    end
    step();
    in_ready = 1'b0;
    is_last  = 1'b0;
    exp2 = {64'h0102010000000000, {7{64'h0}}, 64'h80};
    wait_ready(n);
    checks++;
    if (n !== 9 || out_block !== exp2 || out_last !== 1'b1) begin
      errors++;
      $display("[TB] FAIL two_second_block got n=%0d %h last=%b exp n=9 %h last=1", n, out_block, out_last, exp2);
    end
    ack_block();
  endtask

  task automatic test_collision();
    logic [OW-1:0] exp;
    int n;
    for (int i = 0; i < 9; i++) begin
      send_word(64'h3000 + 64'(i), 1'b0, 3'd0);
    end
    wait_ready(n);
    checks++;
    if (n !== 1) begin
      errors++;
      $display("[TB] FAIL collide_fill_latency got %0d exp 1", n);
    end
    f_ack    = 1'b1;
    in_word  = 64'hC011_1510_0000_0001;
    is_last  = 1'b0;
    in_ready = 1'b1;
    step();
    f_ack = 1'b0;
    checks++;
    if (buffer_full !== 1'b0 || out_block[W-1:0] !== 64'h3008) begin
      errors++;
      $display("[TB] FAIL collide_not_taken got full=%b low=%h exp full=0 low=3008", buffer_full, out_block[W-1:0]);
    end
    step();
    in_ready = 1'b0;
    exp[OW-1 -: W] = 64'hC011_1510_0000_0001;
    for (int i = 0; i < 7; i++) begin
      exp[OW-1-W*(i+1) -: W] = 64'h4000 + 64'(i);
      send_word(64'h4000 + 64'(i), 1'b0, 3'd4);
    end
    exp[W-1:0] = 64'h0123456789ABCD81;
    send_word(64'h0123456789ABCDEF, 1'b1, 3'd7);
    wait_ready(n);
    checks++;
    if (n !== 1 || out_block !== exp || out_last !== 1'b1) begin
      errors++;
      $display("[TB] FAIL collide_count got n=%0d %h last=%b exp n=1 %h last=1", n, out_block, out_last, exp);
    end
    ack_block();
  endtask

  task automatic test_reset_mid_pad();
    logic [OW-1:0] exp;
    int n;
    send_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'd0);
    step();
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_block !== '0 || out_ready !== 1'b0 || buffer_full !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_pad got out=%h rdy=%b full=%b last=%b exp all zero",
               out_block, out_ready, buffer_full, out_last);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    exp = {64'h5A01000000000000, {7{64'h0}}, 64'h80};
    send_word(64'h5A6B7C8D9EAFB0C1, 1'b1, 3'd1);
    ack_block();
    wait_ready(n);
    checks++;
    if (n !== 8 || out_block !== exp || out_last !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_fresh_msg got n=%0d %h last=%b exp n=8 %h last=1", n, out_block, out_last, exp);
    end
    ack_block();
  endtask

  initial begin
    test_reset();
    test_empty();
    test_short();
    test_final_slot();
    test_two_blocks();
    test_collision();
    test_reset_mid_pad();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

endmodule
